// File: rtl/lock_ctrl.sv
// lock_ctrl: sequencing FSM for the digital lock.
// Captures an 8-digit hex password in INIT, checks one entered digit per step
// (LS0..LS7), and reports OPEN or ALARM. Outputs feed the display block.
// Keypad input is a synchronised keycode plus a level strobe; one event per press.
module lock_ctrl #(
    parameter int unsigned MAX_TRIES = 3,       // wrong-digit attempts before ALARM (1..7)
    parameter logic [4:0]  KEY_SET   = 5'd16,   // commit password (INIT) / relock (OPEN)
    parameter logic [4:0]  KEY_CLR   = 5'd17    // clear entry buffer (INIT)
) (
    input  logic        hz100,
    input  logic        reset,
    input  logic [4:0]  keycode,
    input  logic        strobe,
    output logic [3:0]  state,
    output logic [31:0] seq,
    output logic [2:0]  tries_left
);

    localparam logic [2:0] TRIES_INIT = 3'(MAX_TRIES);

    // The numeric values are visible on the state output, so they are fixed here.
    typedef enum logic [3:0] {
        ST_LS0   = 4'd0,
        ST_LS1   = 4'd1,
        ST_LS2   = 4'd2,
        ST_LS3   = 4'd3,
        ST_LS4   = 4'd4,
        ST_LS5   = 4'd5,
        ST_LS6   = 4'd6,
        ST_LS7   = 4'd7,
        ST_OPEN  = 4'd8,
        ST_ALARM = 4'd9,
        ST_INIT  = 4'd10
    } state_e;

    state_e      state_q, state_d;
    logic [31:0] seq_q,   seq_d;
    logic [2:0]  tries_q, tries_d;
    logic        strobe_q;

    logic        press;
    logic        is_digit;
    logic [3:0]  digit;
    logic [2:0]  lock_idx;
    logic [3:0]  exp_digit;

    // Remember last strobe level so a held key yields exactly one event.
    always_ff @(posedge hz100) begin
        // NOTE: reset is synchronous here, so it sits inside the clocked branch
        // and the sensitivity list carries only the clock.
        if (reset) begin
            // Preset high: a key already held while reset releases is not a press.
            strobe_q <= 1'b1;
        end else begin
            strobe_q <= strobe;
        end
    end

    // Key decode and expected digit for the current lock step.
    assign press     = strobe & ~strobe_q;
    assign is_digit  = ~keycode[4];
    assign digit     = keycode[3:0];
    assign lock_idx  = state_q[2:0];
    // Step n checks password digit 7-n, i.e. seq[31-4n -: 4].
    assign exp_digit = 4'(seq_q >> (5'd28 - {lock_idx, 2'b00}));

    // Next-state, password and attempt-counter logic.
    always_comb begin
        // NOTE: every output of this block gets a default first so no path
        // leaves a value unassigned, which would infer a latch.
        state_d = state_q;
        seq_d   = seq_q;
        tries_d = tries_q;

        case (state_q)
            ST_INIT: begin
                if (press) begin
                    if (is_digit) begin
                        // Newest digit enters at the right; oldest drops off the left.
                        seq_d = {seq_q[27:0], digit};
                    end else if (keycode == KEY_CLR) begin
                        seq_d = 32'h0;
                    end else if (keycode == KEY_SET) begin
                        state_d = ST_LS0;
                        tries_d = TRIES_INIT;
                    end
                end
            end

            ST_LS0, ST_LS1, ST_LS2, ST_LS3,
            ST_LS4, ST_LS5, ST_LS6, ST_LS7: begin
                if (press && is_digit) begin
                    if (digit == exp_digit) begin
                        if (lock_idx == 3'd7) begin
                            state_d = ST_OPEN;
                            tries_d = TRIES_INIT;
                        end else begin
                            state_d = state_e'({1'b0, lock_idx + 3'd1});
                        end
                    end else if (tries_q <= 3'd1) begin
                        // Last attempt used up.
                        state_d = ST_ALARM;
                        tries_d = 3'd0;
                    end else begin
                        // A wrong digit restarts the whole sequence.
                        state_d = ST_LS0;
                        tries_d = tries_q - 3'd1;
                    end
                end
            end

            ST_OPEN: begin
                if (press && (keycode == KEY_SET)) begin
                    state_d = ST_LS0;
                end
            end

            ST_ALARM: begin
                // Absorbing; only reset leaves this state.
                tries_d = 3'd0;
            end

            default: begin
                // Unused encodings recover to INIT; password untouched.
                state_d = ST_INIT;
            end
        endcase
    end

    // State, password and counter registers.
    always_ff @(posedge hz100) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples the pre-edge values regardless of statement order.
        if (reset) begin
            state_q <= ST_INIT;
            seq_q   <= 32'h0;
            tries_q <= TRIES_INIT;
        end else begin
            state_q <= state_d;
            seq_q   <= seq_d;
            tries_q <= tries_d;
        end
    end

    // All outputs come straight from registers.
    assign state      = state_q;
    assign seq        = seq_q;
    assign tries_left = tries_q;

endmodule
